// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory request/response, decode handshake
// and the controller's redirect inputs.
interface instruction_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_bit5;
  logic        redirect_valid;
  logic [1:0]  PC_src;
  logic [31:0] PC_target;
  logic [31:0] jalr_target;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid, instr, instr_pc, opcode, funct3, funct7_bit5,
    input  instr_ready,
    input  redirect_valid, PC_src, PC_target, jalr_target
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid, instr, instr_pc, opcode, funct3, funct7_bit5,
    output instr_ready,
    output redirect_valid, PC_src, PC_target, jalr_target
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one outstanding fetch at a time
// and hands the fetched word to decode; redirects on branch/jal/jalr.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        kill_reg;
  logic        req_valid_reg;
  logic [31:0] req_addr_reg;
  logic        instr_valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] instr_pc_reg;

  logic        redirect;
  logic [31:0] new_pc;
  logic [31:0] pc_plus4;
  logic        unused_low_bits;

  assign redirect = bus.redirect_valid && (bus.PC_src != 2'b00);
  // Both targets are forced word-aligned: no compressed ISA support.
  assign new_pc   = bus.PC_src[1] ? {bus.jalr_target[31:2], 2'b00}
                                  : {bus.PC_target[31:2], 2'b00};
  assign pc_plus4 = pc_reg + 32'd4;
  assign unused_low_bits = ^{bus.jalr_target[1:0], bus.PC_target[1:0]};

  assign bus.imem_req_valid = req_valid_reg;
  assign bus.imem_req_addr  = req_addr_reg;
  assign bus.instr_valid    = instr_valid_reg;
  assign bus.instr          = instr_reg;
  assign bus.instr_pc       = instr_pc_reg;
  assign bus.opcode         = instr_reg[6:0];
  assign bus.funct3         = instr_reg[14:12];
  assign bus.funct7_bit5    = instr_reg[30];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      kill_reg        <= 1'b0;
      req_valid_reg   <= 1'b0;
      req_addr_reg    <= RESET_PC;
      instr_valid_reg <= 1'b0;
      instr_reg       <= NOP_INSTR;
      instr_pc_reg    <= RESET_PC;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg     <= REQ;
          req_valid_reg <= 1'b1;
          pc_reg        <= redirect ? new_pc : pc_reg;
          req_addr_reg  <= redirect ? new_pc : pc_reg;
        end
        REQ: begin
          // The in-flight request keeps its old address; its data is killed later.
          if (redirect) begin
            pc_reg   <= new_pc;
            kill_reg <= 1'b1;
          end
          if (bus.imem_req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) pc_reg <= new_pc;
          if (bus.imem_rsp_valid) begin
            if (kill_reg || redirect) begin
              kill_reg      <= 1'b0;
              state_reg     <= REQ;
              req_valid_reg <= 1'b1;
              req_addr_reg  <= redirect ? new_pc : pc_reg;
            end else begin
              instr_reg       <= bus.imem_rsp_data;
              instr_pc_reg    <= pc_reg;
              instr_valid_reg <= 1'b1;
              state_reg       <= HOLD;
            end
          end else if (redirect) begin
            kill_reg <= 1'b1;
          end
        end
        HOLD: begin
          // A redirect drops the held instruction even if decode accepts it now.
          if (redirect || bus.instr_ready) begin
            pc_reg          <= redirect ? new_pc : pc_plus4;
            req_addr_reg    <= redirect ? new_pc : pc_plus4;
            req_valid_reg   <= 1'b1;
            instr_valid_reg <= 1'b0;
            instr_reg       <= NOP_INSTR;
            state_reg       <= REQ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  rsp_only_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_rsp_valid |-> (state_reg == WAIT)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small one-outstanding
// instruction memory model of configurable response latency.
module tb_instruction_fetch_unit;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: hand-chosen words per fetch address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;
      32'h0000_0004: mem_word = 32'h0000_40B3;
      32'h0000_0008: mem_word = 32'hDEAD_BEEF;
      32'h0000_0100: mem_word = 32'h0010_00B3;
      32'h0000_0200: mem_word = 32'h0020_00B3;
      32'hFFFF_FFFC: mem_word = 32'hFFFF_C0B3;
      default:       mem_word = 32'h0000_0013;
    endcase
  endfunction

  logic        acc_seen = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic        pend     = 1'b0;
  logic [31:0] pend_addr;
  int          cnt      = 0;
  int          rsp_delay = 0;

  always @(posedge clk) begin
    if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
      acc_seen = 1'b1;
      acc_addr = bus.imem_req_addr;
    end
  end

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend     = 1'b0;
        acc_seen = 1'b0;
      end else begin
        if (acc_seen) begin
          pend      = 1'b1;
          pend_addr = acc_addr;
          cnt       = rsp_delay;
          acc_seen  = 1'b0;
        end
        if (pend) begin
          if (cnt == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend_addr);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (!bus.imem_req_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd1);
    check({tag, "_req_addr"}, bus.imem_req_addr, exp_addr);
  endtask

  task automatic wait_instr(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    int n = 0;
    while (!bus.instr_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_pc"}, bus.instr_pc, exp_pc);
    check({tag, "_instr"}, bus.instr, exp_instr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
    check({tag, "_req_addr"}, bus.imem_req_addr, 32'h0);
    check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'h0000_0013);
    check({tag, "_instr_pc"}, bus.instr_pc, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.PC_src         = 2'b00;
    bus.PC_target      = 32'h0;
    bus.jalr_target    = 32'h0;
    repeat (3) step();
    check_reset_outputs("rst");

    // Release: IDLE for one cycle, then the first request at RESET_PC.
    rst_n = 1'b1;
    check("idle_no_req", 32'(bus.imem_req_valid), 32'd0);
    step();
    check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("first_req_addr", bus.imem_req_addr, 32'h0);
    wait_instr("i0", 32'h0, 32'h0050_0093);
    check("i0_opcode", 32'(bus.opcode), 32'h13);
    check("i0_funct3", 32'(bus.funct3), 32'h0);

    // Memory stalls the next request for 5 cycles.
    bus.imem_req_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus.imem_req_valid), 32'd1);
      check("stall_addr", bus.imem_req_addr, 32'h4);
      check("stall_no_instr", 32'(bus.instr_valid), 32'd0);
      step();
    end
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b0;
    wait_instr("i4", 32'h4, 32'h0000_40B3);

    // Decode stalls for 4 cycles: held outputs must not move.
    for (int i = 0; i < 4; i++) begin
      check("hold_instr", bus.instr, 32'h0000_40B3);
      check("hold_pc", bus.instr_pc, 32'h4);
      check("hold_opcode", 32'(bus.opcode), 32'h33);
      check("hold_funct3", 32'(bus.funct3), 32'h4);
      check("hold_f7b5", 32'(bus.funct7_bit5), 32'h0);
      step();
    end

    // Branch redirect coincident with instr_ready: held instruction dropped.
    bus.redirect_valid = 1'b1;
    bus.PC_src         = 2'b01;
    bus.PC_target      = 32'h100;
    bus.instr_ready    = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    check("br_drop_valid", 32'(bus.instr_valid), 32'd0);
    check("br_drop_instr", bus.instr, 32'h0000_0013);
    check("br_req_addr", bus.imem_req_addr, 32'h100);
    wait_instr("i100", 32'h100, 32'h0010_00B3);

    // Branch to 0x8, then jalr to 0x203 while the 0x8 fetch is in WAIT.
    rsp_delay          = 3;
    bus.redirect_valid = 1'b1;
    bus.PC_src         = 2'b01;
    bus.PC_target      = 32'h8;
    step();
    bus.redirect_valid = 1'b0;
    check("to8_req_addr", bus.imem_req_addr, 32'h8);
    step();
    bus.redirect_valid = 1'b1;
    bus.PC_src         = 2'b10;
    bus.jalr_target    = 32'h203;
    step();
    bus.redirect_valid = 1'b0;
    for (int n = 0; n < 20 && !bus.imem_req_valid; n++) begin
      check("kill_no_instr", 32'(bus.instr_valid), 32'd0);
      step();
    end
    check("jalr_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("jalr_req_addr", bus.imem_req_addr, 32'h200);
    check("kill_instr_nop", bus.instr, 32'h0000_0013);
    rsp_delay = 0;
    wait_instr("i200", 32'h200, 32'h0020_00B3);

    // jalr to 0xFFFFFFFF lands on 0xFFFFFFFC; sequential fetch wraps to 0.
    bus.redirect_valid = 1'b1;
    bus.PC_src         = 2'b11;
    bus.jalr_target    = 32'hFFFF_FFFF;
    step();
    bus.redirect_valid = 1'b0;
    check("top_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    wait_instr("itop", 32'hFFFF_FFFC, 32'hFFFF_C0B3);
    check("itop_f7b5", 32'(bus.funct7_bit5), 32'h1);
    rsp_delay       = 3;
    bus.instr_ready = 1'b1;
    step();
    wait_req("wrap", 32'h0);

    // Reset while the fetch of 0x0 is in WAIT.
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    step();
    rsp_delay          = 0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.PC_src         = 2'b00;
    bus.PC_target      = 32'h500;
    bus.jalr_target    = 32'h600;
    rst_n = 1'b1;
    step();
    check("restart_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("restart_req_addr", bus.imem_req_addr, 32'h0);
    wait_instr("restart", 32'h0, 32'h0050_0093);
    step();
    step();
    check("src00_hold_valid", 32'(bus.instr_valid), 32'd1);
    check("src00_hold_pc", bus.instr_pc, 32'h0);
    bus.redirect_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Produces the instruction stream that feeds the controller: holds the PC and issues one-outstanding-request fetches to instruction memory.
- Presents the fetched word and its decoded fields (opcode, funct3, funct7_bit5) to decode with a valid/ready handshake.
- Consumes the controller's PC_src encoding to redirect on branch, jal and jalr.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and the first fetch address.
- NOP_INSTR, 32'h0000_0013, value of instr while no instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  32  fetch byte address; always word-aligned.
- imem_req_ready  input  1  memory accepts the request.
- imem_rsp_valid  input  1  response data valid; exactly one per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction word.
- instr_valid  output  1  instruction held for decode.
- instr_ready  input  1  decode consumes the instruction.
- instr  output  32  held instruction word.
- instr_pc  output  32  address of instr.
- opcode  output  7  instr[6:0].
- funct3  output  3  instr[14:12].
- funct7_bit5  output  1  instr[30].
- redirect_valid  input  1  execute resolved the consumed instruction's control flow this cycle.
- PC_src  input  2  controller encoding: 00 sequential, 01 branch/jal taken, 1x jalr.
- PC_target  input  32  PC+imm target for PC_src=01.
- jalr_target  input  32  ALU result for PC_src=1x.

Behaviour:
- Reset (async assert, synchronous release):
  - state=IDLE, pc=RESET_PC, imem_req_valid=0, imem_req_addr=RESET_PC.
  - instr_valid=0, instr=NOP_INSTR, instr_pc=RESET_PC, kill=0.
  - Instruction memory shares rst_n; no response from before reset is ever delivered.
- Field outputs are combinational slices of the instr register.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_valid=1, imem_req_addr=pc. Addr is stable while valid && !ready. Goes to WAIT on imem_req_ready.
  - WAIT: on imem_rsp_valid:
    - if kill=1: discard data, clear kill, go to REQ (pc already updated).
    - else: load instr=imem_rsp_data, instr_pc=pc, instr_valid=1, go to HOLD.
  - HOLD: instr_valid=1 until instr_ready.
    - On consume: pc=pc+4, instr_valid=0, instr=NOP_INSTR, go to REQ.
- Redirect (redirect_valid=1 and PC_src!=00) computes new_pc:
  - PC_src=01: {PC_target[31:2],2'b00}.
  - PC_src=1x: {jalr_target[31:2],2'b00} (bit 0 cleared per jalr; bit 1 cleared since no compressed ISA).
- redirect_valid with PC_src=00 is ignored.
- Redirect handling by state:
  - In HOLD: pc=new_pc, instr_valid=0, go to REQ. Overrides a simultaneous instr_ready; the held instruction is dropped, not consumed.
  - In REQ: request completes at the old address; pc=new_pc, kill=1; the response is discarded in WAIT.
  - In REQ when the same cycle has imem_req_ready=1: same as above.
  - In WAIT: pc=new_pc, kill=1. If the response arrives the same cycle, it is discarded and the next state is REQ.
  - In IDLE: pc=new_pc.
  - A second redirect before the kill resolves overwrites pc (latest wins); kill stays 1.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Throughput: at most one request outstanding. Best case 3 cycles per instruction (REQ accepted, WAIT 1 cycle, HOLD consumed).
- imem_rsp_valid outside WAIT is a protocol violation; it is ignored and assertion-checked.

Test Plan:
- Reset, zero-wait memory, instr_ready=1, memory returns 32'h00500093 at 0x0:
  - first imem_req_valid on cycle 2 after release, addr=0x0.
  - instr_valid with opcode=7'h13, funct3=0, instr_pc=0.
  - next request addr=0x4.
- imem_req_ready held low 5 cycles: imem_req_valid stays 1 and addr stays constant; no response accepted early.
- HOLD with instr_ready=0 for 4 cycles: instr, instr_pc and fields stable.
- Then redirect_valid=1, PC_src=01, PC_target=0x100, same cycle as instr_ready=1: instruction dropped, next request addr=0x100.
- Redirect PC_src=10, jalr_target=0x203 during WAIT for addr 0x8: response 32'hDEADBEEF never appears on instr; next request addr=0x200.
- pc=32'hFFFF_FFFC consumed sequentially: next request addr=0x0.
- rst_n asserted mid-WAIT: outputs immediately at reset values. After release, fetch restarts at RESET_PC; redirect_valid with PC_src=00 causes no change.
